// File: rtl/qpsk_pkg.sv
// Shared constants and types for the QPSK phase generator.
// Gray-coded symbol offsets and FSM state encoding.
package qpsk_pkg;

    localparam int LUT_ADDR_W = 8;

    localparam logic [LUT_ADDR_W-1:0] OFF_00 = 8'd32;
    localparam logic [LUT_ADDR_W-1:0] OFF_01 = 8'd96;
    localparam logic [LUT_ADDR_W-1:0] OFF_11 = 8'd160;
    localparam logic [LUT_ADDR_W-1:0] OFF_10 = 8'd224;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic logic [LUT_ADDR_W-1:0] gray_off(
        input logic [1:0] d
    );
        logic [LUT_ADDR_W-1:0] off;
        unique case (d)
            2'b00:   off = OFF_00;
            2'b01:   off = OFF_01;
            2'b11:   off = OFF_11;
            default: off = OFF_10;
        endcase
        return off;
    endfunction

endpackage

// File: rtl/qpsk_bit_pair.sv
// Serial bit intake: pairs bits into a dibit held until consumed.
// First bit of a pair is the MSB; intake stalls while a dibit waits.
module qpsk_bit_pair
    import qpsk_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable_i,
    input  logic       bit_i,
    input  logic       valid_i,
    output logic       ready_o,
    input  logic       take_i,
    output logic [1:0] dibit_o,
    output logic       dibit_valid_o
);

    logic       half_q, half_d;
    logic       half_vld_q, half_vld_d;
    logic [1:0] next_q, next_d;
    logic       next_vld_q, next_vld_d;

    assign ready_o       = reset_n & enable_i & ~next_vld_q;
    assign dibit_o       = next_q;
    assign dibit_valid_o = next_vld_q;

    // Holding registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            half_q     <= 1'b0;
            half_vld_q <= 1'b0;
            next_q     <= 2'b00;
            next_vld_q <= 1'b0;
        end else begin
            half_q     <= half_d;
            half_vld_q <= half_vld_d;
            next_q     <= next_d;
            next_vld_q <= next_vld_d;
        end
    end

    // Accept bits, complete dibits, release a dibit when the FSM takes it.
    always_comb begin
        half_d     = half_q;
        half_vld_d = half_vld_q;
        next_d     = next_q;
        next_vld_d = next_vld_q;
        if (!enable_i) begin
            half_d     = 1'b0;
            half_vld_d = 1'b0;
            next_d     = 2'b00;
            next_vld_d = 1'b0;
        end else begin
            if (take_i) begin
                next_vld_d = 1'b0;
            end
            if (valid_i && ready_o) begin
                if (half_vld_q) begin
                    next_d     = {half_q, bit_i};
                    next_vld_d = 1'b1;
                    half_vld_d = 1'b0;
                end else begin
                    half_d     = bit_i;
                    half_vld_d = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/qpsk_phase_gen.sv
// NCO phase accumulator plus symbol FSM producing the sine LUT address.
// Address = carrier phase (top accumulator bits) + Gray symbol offset.
module qpsk_phase_gen
    import qpsk_pkg::*;
#(
    parameter int ACC_W = 24,
    parameter int SPS   = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [ACC_W-1:0]      fcw,
    input  logic                  bit_in,
    input  logic                  bit_valid,
    output logic                  bit_ready,
    output logic [LUT_ADDR_W-1:0] lut_addr,
    output logic                  addr_valid,
    output logic                  sym_strobe,
    output logic                  underrun
);

    localparam int CNT_W = $clog2(SPS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPS - 1);

    state_t                  state_q, state_d;
    logic [ACC_W-1:0]        acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [LUT_ADDR_W-1:0]   off_q, off_d;
    logic [LUT_ADDR_W-1:0]   addr_q, addr_d;
    logic                    av_q, av_d;
    logic                    stb_q, stb_d;
    logic                    und_q, und_d;

    logic       load;
    logic       last;
    logic [1:0] dibit;
    logic       dibit_vld;

    qpsk_bit_pair u_pair (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable_i      (enable),
        .bit_i         (bit_in),
        .valid_i       (bit_valid),
        .ready_o       (bit_ready),
        .take_i        (load),
        .dibit_o       (dibit),
        .dibit_valid_o (dibit_vld)
    );

    assign last       = (cnt_q == CNT_LAST);
    assign lut_addr   = addr_q;
    assign addr_valid = av_q;
    assign sym_strobe = stb_q;
    assign underrun   = und_q;

    // State, accumulator and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            off_q   <= '0;
            addr_q  <= '0;
            av_q    <= 1'b0;
            stb_q   <= 1'b0;
            und_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            off_q   <= off_d;
            addr_q  <= addr_d;
            av_q    <= av_d;
            stb_q   <= stb_d;
            und_q   <= und_d;
        end
    end

    // Next state: start on a queued dibit, chain or stop at symbol end.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (dibit_vld) begin
                        state_d = RUN;
                        load    = 1'b1;
                    end
                end
                RUN: begin
                    if (last) begin
                        if (dibit_vld) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath and outputs: phase sum, symbol counter, strobes.
    always_comb begin
        acc_d  = '0;
        cnt_d  = '0;
        off_d  = '0;
        addr_d = '0;
        av_d   = 1'b0;
        stb_d  = 1'b0;
        und_d  = 1'b0;
        if (enable) begin
            acc_d = acc_q + fcw;
            cnt_d = cnt_q;
            off_d = off_q;
            stb_d = load;
            if (state_q == RUN) begin
                addr_d = acc_q[ACC_W-1 -: LUT_ADDR_W] + off_q;
                av_d   = 1'b1;
                cnt_d  = cnt_q + CNT_W'(1);
                und_d  = last & ~dibit_vld;
            end
            if (load) begin
                off_d = gray_off(dibit);
                cnt_d = '0;
            end
        end
    end

endmodule

// File: tb/tb_qpsk_phase_gen.sv
// Self-checking bench for qpsk_phase_gen.
// Reference: bit queue, remaining-cycle symbol model, plain accumulator sum.
module tb_qpsk_phase_gen;

    localparam int SPS = 64;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic [23:0] fcw;
    logic        bit_in;
    logic        bit_valid;
    logic        bit_ready;
    logic [7:0]  lut_addr;
    logic        addr_valid;
    logic        sym_strobe;
    logic        underrun;

    int checks = 0;
    int passes = 0;

    bit          m_q[$];
    logic [23:0] m_acc;
    bit          m_active;
    int          m_left;
    logic [7:0]  m_off;
    logic [7:0]  m_addr;
    bit          m_av;
    bit          m_stb;
    bit          m_und;
    int          m_accepted;

    qpsk_phase_gen #(.ACC_W(24), .SPS(SPS)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .fcw        (fcw),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .lut_addr   (lut_addr),
        .addr_valid (addr_valid),
        .sym_strobe (sym_strobe),
        .underrun   (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] off_of(input bit a, input bit b);
        int idx;
        if (!a && !b)     idx = 0;
        else if (!a && b) idx = 1;
        else if (a && b)  idx = 2;
        else              idx = 3;
        return 8'(32 + 64 * idx);
    endfunction

    function automatic logic [11:0] dut_vec();
        return {lut_addr, addr_valid, sym_strobe, underrun, bit_ready};
    endfunction

    function automatic logic [11:0] exp_vec();
        bit rdy;
        rdy = reset_n && enable && (m_q.size() < 2);
        return {m_addr, m_av, m_stb, m_und, rdy};
    endfunction

    task automatic model_clear();
        m_q.delete();
        m_acc    = '0;
        m_active = 0;
        m_left   = 0;
        m_off    = '0;
        m_addr   = '0;
        m_av     = 0;
        m_stb    = 0;
        m_und    = 0;
    endtask

    task automatic load_sym();
        m_off = off_of(m_q[0], m_q[1]);
        void'(m_q.pop_front());
        void'(m_q.pop_front());
        m_left   = SPS;
        m_active = 1;
        m_stb    = 1;
    endtask

    // Reference step for the coming clock edge, using current inputs.
    task automatic model_step();
        int   pre;
        bit   acc_ok;
        if (!reset_n || !enable) begin
            model_clear();
            return;
        end
        pre    = m_q.size();
        acc_ok = bit_valid && (pre < 2);
        m_stb  = 0;
        m_und  = 0;
        if (m_active) begin
            m_addr = m_acc[23:16] + m_off;
            m_av   = 1;
            m_left = m_left - 1;
            if (m_left == 0) begin
                if (pre >= 2) load_sym();
                else begin
                    m_active = 0;
                    m_und    = 1;
                end
            end
        end else begin
            m_addr = '0;
            m_av   = 0;
            if (pre >= 2) load_sym();
        end
        if (acc_ok) begin
            m_q.push_back(bit_in);
            m_accepted++;
        end
        m_acc = m_acc + fcw;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        enable    = 1'b1;
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        fcw       = 24'($urandom);
        model_clear();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (dut_vec() !== 12'h000)
                $display("FAIL reset_hold: got %h want 000", dut_vec());
            else passes++;
        end
        bit_valid = 1'b0;
        enable    = 1'b0;
        reset_n   = 1'b1;
        #1;
        checks++;
        if (bit_ready !== 1'b0)
            $display("FAIL ready_disabled: got %b want 0", bit_ready);
        else passes++;
        enable = 1'b1;
        #1;
        checks++;
        if (bit_ready !== 1'b1)
            $display("FAIL ready_enabled: got %b want 1", bit_ready);
        else passes++;
        tick();
    endtask

    task automatic test_single_symbol();
        logic [11:0] ex;
        enable = 1'b0;
        tick();
        enable = 1'b1;
        fcw    = 24'h010000;
        for (int i = 0; i < 253; i++) begin
            tick();
            checks++;
            if (dut_vec() !== exp_vec())
                $display("FAIL single_idle: got %h want %h",
                         dut_vec(), exp_vec());
            else passes++;
        end
        bit_valid = 1'b1;
        bit_in    = 1'b0;
        tick();
        tick();
        bit_valid = 1'b0;
        tick();
        checks++;
        if (sym_strobe !== 1'b1 || addr_valid !== 1'b0)
            $display("FAIL single_strobe: got %b%b want 10",
                     sym_strobe, addr_valid);
        else passes++;
        for (int i = 0; i < SPS; i++) begin
            tick();
            ex = {8'(32 + i), 1'b1, 1'b0, (i == SPS - 1), 1'b1};
            checks++;
            if (dut_vec() !== ex)
                $display("FAIL single_addr[%0d]: got %h want %h",
                         i, dut_vec(), ex);
            else passes++;
            checks++;
            if (dut_vec() !== exp_vec())
                $display("FAIL single_model[%0d]: got %h want %h",
                         i, dut_vec(), exp_vec());
            else passes++;
        end
        tick();
        checks++;
        if ({lut_addr, addr_valid, underrun} !== 10'h000)
            $display("FAIL single_end: got %h/%b/%b want 0",
                     lut_addr, addr_valid, underrun);
        else passes++;
    endtask

    task automatic test_back_to_back();
        int stb_n = 0;
        int av_n  = 0;
        int und_n = 0;
        enable = 1'b0;
        tick();
        enable    = 1'b1;
        fcw       = 24'($urandom);
        bit_valid = 1'b1;
        bit_in    = 1'b0;
        tick();
        bit_in = 1'b1;
        tick();
        bit_valid = 1'b0;
        for (int i = 0; i < 140; i++) begin
            if (i == 10) begin
                bit_valid = 1'b1;
                bit_in    = 1'b1;
            end
            if (i == 12) bit_valid = 1'b0;
            tick();
            stb_n += int'(sym_strobe);
            av_n  += int'(addr_valid);
            und_n += int'(underrun);
            checks++;
            if (dut_vec() !== exp_vec())
                $display("FAIL b2b_model[%0d]: got %h want %h",
                         i, dut_vec(), exp_vec());
            else passes++;
        end
        checks++;
        if (stb_n != 2 || av_n != 2 * SPS || und_n != 1)
            $display("FAIL b2b_counts: got %0d/%0d/%0d want 2/%0d/1",
                     stb_n, av_n, und_n, 2 * SPS);
        else passes++;
    endtask

    task automatic test_wrap();
        logic [7:0] exp_w[4];
        exp_w[0] = 8'd224;
        exp_w[1] = 8'd240;
        exp_w[2] = 8'd0;
        exp_w[3] = 8'd16;
        enable = 1'b0;
        tick();
        enable    = 1'b1;
        fcw       = 24'h100000;
        bit_valid = 1'b0;
        repeat (13) tick();
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        tick();
        bit_in = 1'b0;
        tick();
        bit_valid = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (lut_addr !== exp_w[i] || addr_valid !== 1'b1)
                $display("FAIL wrap[%0d]: got %0d/%b want %0d/1",
                         i, lut_addr, addr_valid, exp_w[i]);
            else passes++;
        end
        for (int i = 0; i < 64; i++) begin
            tick();
            checks++;
            if (dut_vec() !== exp_vec())
                $display("FAIL wrap_model[%0d]: got %h want %h",
                         i, dut_vec(), exp_vec());
            else passes++;
        end
    endtask

    task automatic test_backpressure();
        int stb_n = 0;
        enable = 1'b0;
        tick();
        enable     = 1'b1;
        fcw        = 24'($urandom);
        m_accepted = 0;
        for (int i = 0; i < 340; i++) begin
            bit_valid = (i < 200);
            bit_in    = 1'($urandom);
            tick();
            stb_n += int'(sym_strobe);
            checks++;
            if (dut_vec() !== exp_vec())
                $display("FAIL bp_model[%0d]: got %h want %h",
                         i, dut_vec(), exp_vec());
            else passes++;
        end
        checks++;
        if (stb_n != m_accepted / 2)
            $display("FAIL bp_symbols: got %0d want %0d",
                     stb_n, m_accepted / 2);
        else passes++;
    endtask

    task automatic test_enable_drop();
        bit         b0;
        bit         b1;
        logic [7:0] ex;
        enable = 1'b0;
        tick();
        enable    = 1'b1;
        fcw       = 24'($urandom);
        bit_valid = 1'b1;
        bit_in    = 1'($urandom);
        tick();
        bit_in = 1'($urandom);
        tick();
        bit_valid = 1'b0;
        tick();
        repeat (19) tick();
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        tick();
        bit_valid = 1'b0;
        enable    = 1'b0;
        tick();
        checks++;
        if (dut_vec() !== 12'h000)
            $display("FAIL drop_clear: got %h want 000", dut_vec());
        else passes++;
        b0        = 1'($urandom);
        b1        = 1'($urandom);
        enable    = 1'b1;
        bit_valid = 1'b1;
        bit_in    = b0;
        tick();
        bit_in = b1;
        tick();
        bit_valid = 1'b0;
        tick();
        checks++;
        if (sym_strobe !== 1'b1)
            $display("FAIL drop_restart_stb: got %b want 1", sym_strobe);
        else passes++;
        tick();
        ex = 8'((3 * fcw) >> 16) + off_of(b0, b1);
        checks++;
        if (lut_addr !== ex || addr_valid !== 1'b1)
            $display("FAIL drop_restart_addr: got %0d want %0d",
                     lut_addr, ex);
        else passes++;
        for (int i = 0; i < 66; i++) begin
            tick();
            checks++;
            if (dut_vec() !== exp_vec())
                $display("FAIL drop_model[%0d]: got %h want %h",
                         i, dut_vec(), exp_vec());
            else passes++;
        end
    endtask

    task automatic test_async_reset();
        enable    = 1'b1;
        fcw       = 24'($urandom);
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        tick();
        tick();
        bit_valid = 1'b0;
        repeat (12) tick();
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if (dut_vec() !== 12'h000)
            $display("FAIL async_reset: got %h want 000", dut_vec());
        else passes++;
        model_clear();
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        checks++;
        if (dut_vec() !== exp_vec())
            $display("FAIL async_release: got %h want %h",
                     dut_vec(), exp_vec());
        else passes++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            enable    = ($urandom_range(0, 59) != 0);
            bit_valid = 1'($urandom);
            bit_in    = 1'($urandom);
            if ($urandom_range(0, 99) == 0) fcw = 24'($urandom);
            tick();
            checks++;
            if (dut_vec() !== exp_vec())
                $display("FAIL rand_model[%0d]: got %h want %h",
                         i, dut_vec(), exp_vec());
            else passes++;
        end
    endtask

    initial begin
        m_accepted = 0;
        test_reset();
        test_single_symbol();
        test_back_to_back();
        test_wrap();
        test_backpressure();
        test_enable_drop();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
